// File: rtl/video_pkg.sv
// Shared definitions for the video fetch path: fetch FSM encoding and the
// default frame geometry used to size one frame of 32-bit (two-pixel) words.
package video_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    // Two 16-bit pixels are packed per 32-bit memory word.
    function automatic int words_per_frame(input int h_res, input int v_res);
        return (h_res * v_res) / 2;
    endfunction

    localparam int WORDS_PER_FRAME_DEF = words_per_frame(H_RES, V_RES);

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_ISSUE = 2'd1,
        FS_WAIT  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/video_fetch_if.sv
// Burst read port between the video fetcher (master) and the SDRAM arbiter (slave).
interface video_fetch_if #(
    parameter int ADDR_W = 24
);
    // mem_req is held with a stable mem_addr until the one-cycle mem_ack; after the
    // ack exactly one burst of beats follows, each qualified by mem_rvalid, in order.
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  mem_rvalid
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output mem_rvalid
    );

endinterface

// File: rtl/video_fetch_fifo.sv
// Show-ahead FIFO: rdata presents the head combinationally (zero when empty);
// flush empties it in one cycle. Writes into a full FIFO are excluded upstream.
module video_fetch_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_fetch.sv
// Framebuffer prefetcher: bursts SDRAM reads into a show-ahead FIFO for the display
// controller and restarts at the frame base on each vblank rise. VIDEO_FETCH_PAGE_FLIP_EN adds fb_base.
module video_fetch
    import video_pkg::*;
#(
    parameter int                ADDR_W          = 24,
    parameter logic [ADDR_W-1:0] FB_BASE         = 24'h000000,
    parameter int                WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
    parameter int                BURST_LEN       = 8,
    parameter int                FIFO_DEPTH      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblank,
    input  logic              req,
`ifdef VIDEO_FETCH_PAGE_FLIP_EN
    input  logic [ADDR_W-1:0] fb_base,
`endif
    output logic [31:0]       viddata,
    output logic              underflow,
    input  logic              underflow_clr,
    output logic [1:0]        dbg_state,
    video_fetch_if.master     mem
);
    localparam logic [1:0] ST_IDLE  = FS_IDLE;
    localparam logic [1:0] ST_ISSUE = FS_ISSUE;
    localparam logic [1:0] ST_WAIT  = FS_WAIT;
    localparam logic [1:0] ST_DRAIN = FS_DRAIN;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(WORDS_PER_FRAME + 1);
    localparam int BW = $clog2(BURST_LEN + 1);

    localparam logic [WW-1:0] WPF_W   = WW'(WORDS_PER_FRAME);
    localparam logic [WW-1:0] BURST_W = WW'(BURST_LEN);
    localparam logic [31:0]   ISSUE_LIMIT = 32'(FIFO_DEPTH - BURST_LEN);

    logic [1:0]        state;
    logic [WW-1:0]     words_issued;
    logic [BW-1:0]     beats_out;
    logic [BW-1:0]     beats_nxt;
    logic              vblank_q;
    logic              restart_pend;
    logic              restart_ev;
    logic              issue_ok;
    logic              drain_exit;
    logic [31:0]       used_sum;
    logic [ADDR_W-1:0] base_cur;

    logic              fifo_flush;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign restart_ev = vblank & ~vblank_q;
    assign beats_nxt  = beats_out - BW'(mem.mem_rvalid && (beats_out != '0));
    assign drain_exit = (state == ST_DRAIN) && (beats_nxt == '0);

    // Words already in the FIFO plus beats still in flight must leave room for a whole burst.
    assign used_sum = 32'(fifo_count) + 32'(beats_out);
    assign issue_ok = (used_sum <= ISSUE_LIMIT) && (words_issued < WPF_W);

    assign fifo_flush = ((state == ST_IDLE) && restart_ev) || drain_exit;
    assign fifo_push  = mem.mem_rvalid && (state == ST_WAIT);
    assign fifo_pop   = req && !fifo_empty && !restart_ev && !fifo_flush;
    assign dbg_state  = state;

`ifdef VIDEO_FETCH_PAGE_FLIP_EN
    logic [ADDR_W-1:0] base_q;
    logic              first_q;

    // The first cycle after reset uses fb_base directly so frame 0 can start at once.
    assign base_cur = first_q ? fb_base : base_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= FB_BASE;
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (first_q || fifo_flush) begin
                base_q <= fb_base;
            end
        end
    end
`else
    assign base_cur = FB_BASE;
`endif

    video_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (mem.mem_rdata),
        .pop   (fifo_pop),
        .rdata (viddata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
            vblank_q  <= 1'b0;
        end else begin
            underflow <= (req && fifo_empty) || (underflow && !underflow_clr);
            vblank_q  <= vblank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= FB_BASE;
            words_issued <= '0;
            beats_out    <= '0;
            restart_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (restart_ev) begin
                        words_issued <= '0;
                    end else if (issue_ok) begin
                        state        <= ST_ISSUE;
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= base_cur + ADDR_W'(words_issued);
                    end
                end
                ST_ISSUE: begin
                    // A restart here cannot withdraw the request; the burst is drained instead.
                    if (mem.mem_ack) begin
                        mem.mem_req  <= 1'b0;
                        words_issued <= words_issued + BURST_W;
                        beats_out    <= BW'(BURST_LEN);
                        restart_pend <= 1'b0;
                        state        <= (restart_pend || restart_ev) ? ST_DRAIN : ST_WAIT;
                    end else if (restart_ev) begin
                        restart_pend <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    beats_out <= beats_nxt;
                    if (restart_ev) begin
                        state <= ST_DRAIN;
                    end else if (beats_nxt == '0) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    beats_out <= beats_nxt;
                    if (beats_nxt == '0) begin
                        words_issued <= '0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
